// File: rtl/snn_inference_ctrl.sv
// Inference sequencer for a spiking classifier: clears the neurons, runs N timesteps,
// then scans the per-class spike counters for the winner and hands it out with valid/ready.
module snn_inference_ctrl #(
   parameter int unsigned NUM_CLASSES = 10,
   parameter int unsigned WIDTH_P     = 8,
   parameter int unsigned STEP_W      = 8,
   localparam int unsigned CLS_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           start_i,
   input  logic                           abort_i,
   input  logic [STEP_W-1:0]              num_steps_i,
   input  logic [NUM_CLASSES*WIDTH_P-1:0] spike_counts_i,
   output logic                           clear_o,
   output logic                           step_en_o,
   output logic                           busy_o,
   output logic                           result_valid_o,
   input  logic                           result_ready_i,
   output logic [CLS_W-1:0]               result_class_o,
   output logic [WIDTH_P-1:0]             result_count_o
);

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, SCAN, DONE} state_t;

   state_t               state_q;
   state_t               state_n;
   logic [STEP_W-1:0]    steps_q;
   logic [CLS_W-1:0]     scan_idx_q;
   logic [CLS_W-1:0]     best_cls_q;
   logic [CLS_W-1:0]     best_cls_n;
   logic [WIDTH_P-1:0]   best_cnt_q;
   logic [WIDTH_P-1:0]   best_cnt_n;
   logic [WIDTH_P-1:0]   cur_cnt;
   logic                 scan_last;

   assign scan_last = (scan_idx_q == CLS_W'(NUM_CLASSES - 1));

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state logic; abort outranks every form of progress
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:  if (start_i) state_n = CLEAR;
         CLEAR: begin
            if (abort_i)                state_n = IDLE;
            else if (steps_q != '0)     state_n = RUN;
            else                        state_n = SCAN;
         end
         RUN: begin
            if (abort_i)                     state_n = IDLE;
            else if (steps_q == STEP_W'(1))  state_n = SCAN;
         end
         SCAN: begin
            if (abort_i)        state_n = IDLE;
            else if (scan_last) state_n = DONE;
         end
         DONE:  if (abort_i || result_ready_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Select the class under examination and fold it into the running maximum
   always_comb begin
      cur_cnt = '0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
         if (scan_idx_q == CLS_W'(k)) cur_cnt = spike_counts_i[k*WIDTH_P +: WIDTH_P];
      end
      best_cls_n = best_cls_q;
      best_cnt_n = best_cnt_q;
      if ((scan_idx_q == '0) || (cur_cnt > best_cnt_q)) begin
         best_cls_n = scan_idx_q;
         best_cnt_n = cur_cnt;
      end
   end

   // Counters, argmax registers and outputs decoded from the upcoming state
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         steps_q        <= '0;
         scan_idx_q     <= '0;
         best_cls_q     <= '0;
         best_cnt_q     <= '0;
         result_class_o <= '0;
         result_count_o <= '0;
         clear_o        <= 1'b0;
         step_en_o      <= 1'b0;
         busy_o         <= 1'b0;
         result_valid_o <= 1'b0;
      end else begin
         clear_o        <= (state_n == CLEAR);
         step_en_o      <= (state_n == RUN);
         busy_o         <= (state_n != IDLE);
         result_valid_o <= (state_n == DONE);

         if (state_q == IDLE && start_i) steps_q <= num_steps_i;
         else if (state_q == RUN)        steps_q <= steps_q - STEP_W'(1);

         scan_idx_q <= (state_q == SCAN) ? scan_idx_q + CLS_W'(1) : '0;

         if (state_q == SCAN) begin
            best_cls_q <= best_cls_n;
            best_cnt_q <= best_cnt_n;
         end

         // Results only move on a completed scan, so they persist across handshakes and aborts
         if (state_q == SCAN && state_n == DONE) begin
            result_class_o <= best_cls_n;
            result_count_o <= best_cnt_n;
         end
      end
   end

endmodule

// File: doc/snn_inference_ctrl.md
SNN_INFERENCE_CTRL -- requirements
Module: snn_inference_ctrl

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of output neurons/spike counters scanned.
REQ-002 SHALL have parameter WIDTH_P, default 8, width of each spike count.
REQ-003 SHALL have parameter STEP_W, default 8, width of the timestep count.
REQ-004 SHALL have port clk_i, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1, request a new inference run.
REQ-007 SHALL have port abort_i, input, 1, cancel the run in progress.
REQ-008 SHALL have port num_steps_i, input, STEP_W, number of timesteps to run, latched at start.
REQ-009 SHALL have port spike_counts_i, input, NUM_CLASSES*WIDTH_P, packed counts; class k occupies bits [k*WIDTH_P +: WIDTH_P].
REQ-010 SHALL have port clear_o, output, 1, one-cycle clear pulse to the LIF neurons and spike counters.
REQ-011 SHALL have port step_en_o, output, 1, timestep enable to the neurons and counters.
REQ-012 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-013 SHALL have port result_valid_o, output, 1, classification result available.
REQ-014 SHALL have port result_ready_i, input, 1, consumer accepts the result.
REQ-015 SHALL have port result_class_o, output, $clog2(NUM_CLASSES), winning class index.
REQ-016 SHALL have port result_count_o, output, WIDTH_P, spike count of the winning class.

Function
REQ-017 SHALL implement the FSM states IDLE, CLEAR, RUN, SCAN and DONE.
REQ-018 IDLE with start_i=1 SHALL latch num_steps_i and go to CLEAR; start_i in any other state SHALL be ignored.
REQ-019 CLEAR SHALL last exactly 1 cycle with clear_o=1, then go to RUN if the latched steps are nonzero, else go to SCAN.
REQ-020 RUN SHALL assert step_en_o for exactly N consecutive cycles (N = latched steps), using a STEP_W-bit down-counter, then go to SCAN.
REQ-021 clear_o and step_en_o SHALL never be high in the same cycle, and both SHALL be low outside CLEAR and RUN respectively.
REQ-022 SCAN SHALL take exactly NUM_CLASSES cycles and examine class i in scan cycle i (i = 0..NUM_CLASSES-1).
REQ-023 In SCAN, class 0 SHALL initialise the best-so-far, and class i SHALL replace it only if its count is strictly greater; ties therefore resolve to the lowest index.
REQ-024 After the last scan cycle the FSM SHALL go to DONE and register result_class_o and result_count_o.
REQ-025 DONE SHALL hold result_valid_o=1 with stable results until result_ready_i=1; the handshake cycle SHALL return the FSM to IDLE.
REQ-026 With start_i asserted at edge t, the timing SHALL be: CLEAR at t+1, RUN at t+2..t+N+1, SCAN at t+N+2..t+N+11, result_valid_o rising at t+N+12 (for NUM_CLASSES=10).
REQ-027 result_class_o and result_count_o SHALL retain their last values after the handshake until the next DONE.
REQ-028 abort_i=1 in CLEAR, RUN, SCAN or DONE SHALL move the FSM to IDLE on the next edge with no valid result; in IDLE it SHALL have no effect.
REQ-029 abort_i SHALL take priority over the result handshake and over step and scan progression.
REQ-030 Count compares SHALL be unsigned WIDTH_P-bit compares.
REQ-031 An all-zero count vector SHALL yield class 0 with count 0.

Reset
REQ-032 rst_i=1 SHALL force IDLE on the next edge and override all other inputs, including mid-run.
REQ-033 During and after reset, clear_o, step_en_o, busy_o and result_valid_o SHALL be 0, and result_class_o and result_count_o SHALL be 0.

Verification
REQ-034 Start with num_steps_i=5 and counts {3,9,2,0,...} -> 1 clear pulse, 5 step_en cycles, valid at t+17, class 1, count 9.
REQ-035 Start with num_steps_i=0 -> clear pulse, no step_en, valid at t+12, class/count reflect the inputs.
REQ-036 Counts with classes 4 and 7 both at 200, all others lower -> class 4, count 200.
REQ-037 result_ready_i held low for 6 cycles in DONE -> valid and results stable throughout, IDLE the cycle after ready; a start_i pulse during DONE is ignored.
REQ-038 abort_i at the 3rd RUN cycle -> step_en_o low next cycle, busy_o low, no valid; a subsequent start runs a full 1+N+10 sequence.
REQ-039 rst_i pulsed mid-SCAN -> all outputs 0 next cycle; start_i in the same cycle as rst_i is ignored.
